// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder built around one shared
// 1-bit full adder. It processes one bit per clock, LSB first, and reports
// sum, carry-out and signed overflow together with a one-cycle done pulse.
// Optional build macro SERIAL_ADDER_SUB_EN adds a 'sub' input that turns
// the operation into a - b.

// Shared 1-bit full adder cell.
module adder1bit (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);
  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               fa_sum_s;
  logic               fa_cout_s;
  logic [WIDTH-1:0]   b_eff_s;
  logic               cin_eff_s;

  // The single full adder always sees the current LSBs and the carry flop.
  adder1bit u_fa (
    .a_i    (op_a_q[0]),
    .b_i    (op_b_q[0]),
    .cin_i  (carry_q),
    .sum_o  (fa_sum_s),
    .cout_o (fa_cout_s)
  );

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is a + ~b + 1, so invert B and force the initial carry.
  always_comb begin
    b_eff_s   = b;
    cin_eff_s = cin;
    if (sub) begin
      b_eff_s   = ~b;
      cin_eff_s = 1'b1;
    end else begin
      b_eff_s   = b;
      cin_eff_s = cin;
    end
  end
`else
  // Add-only build: operands pass straight through.
  always_comb begin
    b_eff_s   = b;
    cin_eff_s = cin;
  end
`endif

  // Next-state and datapath update for the IDLE/RUN/FINISH sequencer.
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_a_d  = a;
          op_b_d  = b_eff_s;
          carry_d = cin_eff_s;
          cnt_d   = {CNT_W{1'b0}};
          sum_d   = {WIDTH{1'b0}};
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        // New bit enters at the MSB so bit 0 lands in position 0 at the end.
        sum_d   = {fa_sum_s, sum_q[WIDTH-1:1]};
        op_a_d  = op_a_q >> 1;
        op_b_d  = op_b_q >> 1;
        carry_d = fa_cout_s;
        cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // carry_q here is the carry into the MSB.
          cout_d  = fa_cout_s;
          ovf_d   = carry_q ^ fa_cout_s;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_FINISH;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_FINISH: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_a_q  <= {WIDTH{1'b0}};
      op_b_q  <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8). Stimulus pushes the
// expected {sum, cout, overflow}; a monitor pops and compares on each done.
`timescale 1ns/1ps
module tb_serial_adder_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       sub;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       overflow;

  int pass_cnt;
  int total_cnt;
  int done_cnt;
  logic [9:0] exp_q[$];

  serial_adder_ctrl #(.WIDTH(8), .CNT_W(5)) dut (
`ifdef SERIAL_ADDER_SUB_EN
    .sub      (sub),
`endif
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: compare every done pulse against the scoreboard.
  always @(negedge clk) begin
    logic [9:0] e;
    if (!reset && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sum", {24'd0, sum}, {24'd0, e[9:2]});
        check("cout", {31'd0, cout}, {31'd0, e[1]});
        check("overflow", {31'd0, overflow}, {31'd0, e[0]});
      end
    end
  end

  // Issue one operation, checking busy length, latency and done width.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                        input logic ts, input logic [7:0] es, input logic ec, input logic eo);
    int busy_cycles;
    int waited;
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; sub = ts; start = 1'b1;
    exp_q.push_back({es, ec, eo});
    @(posedge clk);
    #1;
    start = 1'b0; a = ~ta; b = ~tb_v; cin = ~tc;
    busy_cycles = 0;
    waited = 0;
    while (waited < 20) begin
      @(negedge clk);
      waited++;
      if (done) break;
      if (busy) busy_cycles++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    check("latency", waited, 32'd9);
    check("busy_cycles", busy_cycles, 32'd8);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int d0;
    pass_cnt = 0; total_cnt = 0; done_cnt = 0;
    reset = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {24'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_op(8'h35, 8'h0A, 1'b0, 1'b0, 8'h3F, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op(8'h7F, 8'h01, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1);
    check("hold_sum_idle", {24'd0, sum}, 32'h81);

    // Start while busy is ignored.
    d0 = done_cnt;
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    exp_q.push_back({8'h30, 1'b0, 1'b0});
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    check("single_done", done_cnt - d0, 32'd1);
    run_op(8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);

    // Leave overflow=1 so the abort check sees it cleared.
    run_op(8'h7F, 8'h01, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1);

    // Reset mid-operation aborts without done.
    d0 = done_cnt;
    @(negedge clk);
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_sum", {24'd0, sum}, 32'd0);
    check("abort_cout", {31'd0, cout}, 32'd0);
    check("abort_ovf", {31'd0, overflow}, 32'd0);
    repeat (12) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 32'd0);
    run_op(8'h02, 8'h03, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    run_op(8'h35, 8'h0A, 1'b0, 1'b0, 8'h3F, 1'b0, 1'b0);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
